flit_input_buffer: RTL
======================

# flit_input_buffer

Per-input-port flit FIFO with XY route computation and wormhole request generation. It sits directly upstream of the router's channel controller. The buffer stores flits from the link and decodes the head flit into a one-hot output-port request, which the router top maps into the controller's HP/LP channel request vectors. It holds that request for the whole packet and streams flits once the controller's grant for its slot arrives.

## Interface
- FLIT_W, 34: flit width; type field in bits [FLIT_W-1:FLIT_W-2].
- DEPTH, 4: FIFO entries; power of two, ≥2.
- COORD_W, 3: width of each destination coordinate.
- ROUTER_X, 0: this router's X coordinate.
- ROUTER_Y, 0: this router's Y coordinate.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  FLIT_W  flit from link.
- in_valid  in  1  in_flit valid.
- in_ready  out  1  buffer can accept; a push occurs when in_valid & in_ready.
- out_flit  out  FLIT_W  FIFO front flit.
- out_valid  out  1  front flit may be taken.
- out_ready  in  1  channel accepts; a pop occurs when out_valid & out_ready.
- route_req  out  5  one-hot: [0] Local, [1] North, [2] East, [3] South, [4] West.
- gnt  in  1  grant for this buffer's request slot from the channel controller.
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  8  orphan-flit drop counter (only with INBUF_DROP_CNT_EN).

## Operation
- Flit types are 2'b01 head, 2'b00 body, 2'b10 tail, and 2'b11 single (head and tail).
- dest_x is flit[2*COORD_W-1:COORD_W] and dest_y is flit[COORD_W-1:0]; both are unsigned.
- XY routing is evaluated in this order:
  - dest_x>ROUTER_X → East; dest_x<ROUTER_X → West.
  - Otherwise dest_y>ROUTER_Y → North; dest_y<ROUTER_Y → South.
  - Otherwise → Local.
- The FIFO uses circular read/write pointers of $clog2(DEPTH) bits that wrap naturally.
  - in_ready = (fifo_cnt < DEPTH).
  - A full FIFO refuses a push even when a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves fifo_cnt unchanged.
- The FSM has three states: IDLE, REQ and XFER.
- **IDLE**
  - route_req=0 and out_valid=0.
  - If the FIFO is non-empty and the front is head or single: latch the route register, then go to REQ.
  - If the front is body or tail (orphan): pop it internally (the FIFO is read, out_valid stays 0), increment drop_cnt, and remain in IDLE.
- **REQ**
  - route_req = route register.
  - On gnt=1 go to XFER; otherwise stay in REQ.
- **XFER**
  - route_req is held (wormhole lock); out_valid = !empty.
  - When a popped flit is tail or single, go to IDLE.
  - gnt is ignored in XFER; the controller must keep the grant while route_req is high.

## Timing
- **Reset values:** in_ready=1, out_valid=0, out_flit=0, route_req=0, fifo_cnt=0, drop_cnt=0; state is IDLE and both pointers are 0.
- **Reset mid-packet:** the FIFO is flushed and route_req drops the cycle after rst is sampled.
- **Head latency:**
  - The head is pushed at edge N.
  - It is seen at the front in cycle N+1.
  - REQ is entered and route_req is high from edge N+2.
- **Grant latency:** gnt sampled high at edge M puts the block in XFER with out_valid high from edge M (same cycle as the transition). The first pop can occur at edge M+1.
- **Packet release:** route_req deasserts at the edge that pops the tail.
- **Back-to-back packets:** a following head is evaluated in IDLE one cycle later, so there is at least one idle cycle between packets.
- out_flit is combinational from FIFO storage at the read pointer and is valid only when out_valid=1.
- drop_cnt saturates at 8'hFF.
- An empty FIFO in XFER holds out_valid=0 and route_req high until the tail arrives.

## Configuration
- INBUF_DROP_CNT_EN defined: the drop_cnt port and the 8-bit saturating counter exist.
- Undefined: the drop_cnt port is absent. Orphan flits are still discarded silently in IDLE, and the rest of the behaviour is identical.

## Test plan
- **Single-flit route:** ROUTER_X=ROUTER_Y=0; push single flit dest (2,1) → route_req=5'b00100 from the second edge after the push; gnt=1 → out_valid; the pop returns the flit and route_req=0 after that edge.
- **4-flit packet with hold:** push head dest (0,3), two bodies and a tail, with out_ready toggling 1/0.
  - route_req=5'b00010 held throughout.
  - Flits emerge in order.
  - Release occurs exactly at the tail pop.
- **Full FIFO:** DEPTH=4; push 4 flits with gnt=0 → in_ready=0 and fifo_cnt=4; a fifth in_valid is not accepted; after grant and one pop → in_ready=1.
- **Orphan drop:** push body then tail with no head → both discarded, out_valid never 1, drop_cnt=2, and with the macro undefined the port is absent.
- **Wrap and simultaneous push/pop:** stream 10 flits with in_valid=out_ready=1 → fifo_cnt stays constant after fill, pointers wrap, and order is preserved.
- **Reset mid-packet:** rst=1 during XFER with 2 flits buffered → next cycle fifo_cnt=0, route_req=0, in_ready=1; a new head routes normally.

Source files
------------

// File: rtl/flit_input_buffer.sv
// flit_input_buffer
// Per-input-port flit FIFO with XY route decode and wormhole request generation.
// The head flit at the FIFO front is decoded into a one-hot output-port request.
// That request is held for the whole packet, and flits stream out once the
// channel controller grants this slot.
// Optional feature macro: INBUF_DROP_CNT_EN adds the drop_cnt port, an 8-bit
// saturating counter of orphan (body/tail without head) flits discarded in IDLE.
module flit_input_buffer #(
  parameter int FLIT_W   = 34,
  parameter int DEPTH    = 4,
  parameter int COORD_W  = 3,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [FLIT_W-1:0]      out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             route_req,
  input  logic                   gnt,
`ifdef INBUF_DROP_CNT_EN
  output logic [7:0]             drop_cnt,
`endif
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [COORD_W-1:0] RX       = COORD_W'(ROUTER_X);
  localparam logic [COORD_W-1:0] RY       = COORD_W'(ROUTER_Y);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

  // One-hot output port encoding of route_req.
  localparam logic [4:0] PORT_L = 5'b00001;
  localparam logic [4:0] PORT_N = 5'b00010;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_W = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [4:0]         route_reg, route_next;
  // Set for one cycle after the head route has been captured in IDLE; the
  // request is raised on the following edge.
  logic               route_ld_reg, route_ld_next;

  logic [FLIT_W-1:0]  entry_q [DEPTH];
  logic               push, pop, empty;
  logic [1:0]         front_type;
  logic               front_is_head, front_is_tail;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic               x_gt, x_lt, y_gt, y_lt;
  logic [4:0]         xy_port;

  assign empty    = (cnt_reg == '0);
  assign in_ready = (cnt_reg < FULL_CNT);
  assign push     = in_valid & in_ready;
  assign fifo_cnt = cnt_reg;

  // Front flit is read combinationally from storage at the read pointer.
  assign out_flit = entry_q[rd_ptr_reg];

  // Type field: bit 0 marks a packet start (head/single), bit 1 a packet end
  // (tail/single). Body and tail at the front in IDLE are orphans.
  assign front_type    = out_flit[FLIT_W-1 -: 2];
  assign front_is_head = front_type[0];
  assign front_is_tail = front_type[1];

  assign dest_x = out_flit[2*COORD_W-1:COORD_W];
  assign dest_y = out_flit[COORD_W-1:0];

  // Relative position of the destination; "less than" is derived from
  // "not equal and not greater" so a router at coordinate 0 never produces a
  // constant comparison.
  assign x_gt = (dest_x > RX);
  assign x_lt = (dest_x != RX) && !x_gt;
  assign y_gt = (dest_y > RY);
  assign y_lt = (dest_y != RY) && !y_gt;

  // FIFO storage: one register per slot, written when the write pointer
  // selects it; slots clear on reset so the front reads zero afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [FLIT_W-1:0] entry_reg;

      // Capture the incoming flit into this slot on a push addressed here.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= in_flit;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Dimension-ordered XY decode of the front flit: X first, then Y, else Local.
  always_comb begin
    xy_port = PORT_L;
    if (x_gt) begin
      xy_port = PORT_E;
    end else if (x_lt) begin
      xy_port = PORT_W;
    end else if (y_gt) begin
      xy_port = PORT_N;
    end else if (y_lt) begin
      xy_port = PORT_S;
    end
  end

  // Circular pointers and occupancy; a push and a pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Packet sequencing: route capture, request/grant handshake, wormhole transfer.
  always_comb begin
    state_next    = state_reg;
    route_next    = route_reg;
    route_ld_next = route_ld_reg;
    route_req     = '0;
    out_valid     = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (route_ld_reg) begin
          route_ld_next = 1'b0;
          state_next    = REQ;
        end else if (!empty) begin
          if (front_is_head) begin
            route_next    = xy_port;
            route_ld_next = 1'b1;
          end else begin
            // Orphan flit: discard it without presenting it downstream.
            pop = 1'b1;
          end
        end
      end
      REQ: begin
        route_req = route_reg;
        if (gnt) begin
          state_next = XFER;
        end
      end
      XFER: begin
        // Request stays asserted until the end-of-packet flit leaves.
        route_req = route_reg;
        out_valid = !empty;
        pop       = !empty && out_ready;
        if (pop && front_is_tail) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched route and route-capture flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      route_reg    <= '0;
      route_ld_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      route_reg    <= route_next;
      route_ld_reg <= route_ld_next;
    end
  end

`ifdef INBUF_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  logic       drop;

  // Any pop taken while IDLE is an orphan discard.
  assign drop     = pop && (state_reg == IDLE);
  assign drop_cnt = drop_cnt_reg;

  // Saturating orphan-drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end
`endif

endmodule
